// File: rtl/riscv_ctrl_seq.sv
// riscv_ctrl_seq: multi-cycle IF/ID/EX/MEM/WB control sequencer with decode, skip and stall timeout
module riscv_ctrl_seq #(
  parameter bit SKIP_UNUSED = 1,
  parameter bit ENABLE_M = 0,
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT_LIMIT = 200
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [6:0] iOpcode,
  input  logic [2:0] iFunct3,
  input  logic [6:0] iFunct7,
  input  logic       iRdy_IF,
  input  logic       iRdy_ALU,
  input  logic       iRdy_MEM,
  input  logic       iFlush,
  output logic [4:0] oStep,
  output logic       oLoad,
  output logic       oStore,
  output logic       oBranch,
  output logic       oImm,
  output logic       oJump,
  output logic       oRegWrite,
  output logic       oIllegal,
  output logic       oTimeout,
  output logic       oRetire
);
  logic [4:0] step, nxt;
  logic [8:0] cls, dec;
  logic [TIMEOUT_W-1:0] cnt;
  logic ok, ill, rdy, hit, last, go, ex;
  // class bits: 0 alui, 1 alur, 2 jalr, 3 jal, 4 lui, 5 auipc, 6 branch, 7 load, 8 store
  assign dec = {iOpcode == 7'b0100011, iOpcode == 7'b0000011, iOpcode == 7'b1100011,
                iOpcode == 7'b0010111, iOpcode == 7'b0110111, iOpcode == 7'b1101111,
                iOpcode == 7'b1100111, iOpcode == 7'b0110011, iOpcode == 7'b0010011};
  always_comb begin
    ok = $onehot(step);
    ill = ~|dec
        | (dec[1] & ~(iFunct7 == 7'h00 | iFunct7 == 7'h20 | (ENABLE_M && iFunct7 == 7'h01)))
        | (dec[0] & iFunct3 == 3'b001 & iFunct7 != 7'h00)
        | (dec[0] & iFunct3 == 3'b101 & ~(iFunct7 == 7'h00 | iFunct7 == 7'h20));
    rdy = step[0] ? iRdy_IF
        : step[2] ? (iRdy_ALU | cls[3] | cls[4])
        : step[3] ? (iRdy_MEM | ~(cls[7] | cls[8]))
        : 1'b1;
    nxt = step[0] ? 5'b00010
        : step[1] ? (ill ? 5'b00001 : 5'b00100)
        : step[2] ? ((!SKIP_UNUSED || cls[7] || cls[8]) ? 5'b01000 : cls[6] ? 5'b00001 : 5'b10000)
        : step[3] ? ((SKIP_UNUSED && (cls[8] || cls[6])) ? 5'b00001 : 5'b10000)
        : 5'b00001;
    hit = ok & ~rdy & (cnt == TIMEOUT_W'(TIMEOUT_LIMIT - 1));
    last = ok & rdy & (|step[4:2]) & nxt[0];
    go = ~iRst & ~iFlush;
    ex = |step[4:2];
  end
  assign oStep = step;
  assign oLoad = ex & cls[7];
  assign oStore = ex & cls[8];
  assign oBranch = ex & cls[6];
  assign oImm = ex & (cls[0] | cls[7] | cls[8] | cls[2] | cls[4] | cls[5]);
  assign oJump = ex & (cls[2] | cls[3]);
  assign oRegWrite = step[4] & (cls[0] | cls[1] | cls[3] | cls[2] | cls[4] | cls[5] | cls[7]);
  assign oIllegal = go & ok & step[1] & ill;
  assign oTimeout = go & hit;
  assign oRetire = go & last;
  always_ff @(posedge iClk) begin
    if (iRst || iFlush) begin
      step <= 5'b00001;
      cnt <= '0;
      cls <= '0;
    end else if (!ok || hit) begin
      step <= 5'b00001;
      cnt <= '0;
    end else if (rdy) begin
      step <= nxt;
      cnt <= '0;
      if (step[1] && !ill) cls <= dec;
    end else cnt <= cnt + 1'b1;
  end
endmodule
